dds_quadrant_reader: RTL and testbench

Quarter-wave ROM reader for the DDS. Consumes the quadrant controls (`memdir`, start address `addr_rd`, `data_pol`) from the quadrant state machine. Walks the quarter-wave table one programmable step per sample tick and emits signed samples. At the end of each quadrant it pulses `trigger` back to the quadrant state machine, carrying the overshoot into the next quadrant so the output frequency is preserved.

---
 rtl/dds_quadrant_reader_if.sv | 31 +++
 rtl/dds_quadrant_reader.sv | 126 ++++++++++++
 tb/tb_dds_quadrant_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_quadrant_reader_if.sv
// dds_quadrant_reader_if: bus between the quadrant reader and its environment
// Signals: enable, tick, step, memdir, addr_rd, data_pol and rom_data flow into
//   the reader; rom_addr, trigger, sample, sample_valid and overrun flow out.
// Modports: slave = the reader, master = the quadrant FSM / ROM side.
interface dds_quadrant_reader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              enable;
    logic              tick;
    logic [ADDR_W-1:0] step;
    logic              memdir;
    logic [ADDR_W-1:0] addr_rd;
    logic              data_pol;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              trigger;
    logic [DATA_W:0]   sample;
    logic              sample_valid;
    logic              overrun;

    modport slave (
        input  enable, tick, step, memdir, addr_rd, data_pol, rom_data,
        output rom_addr, trigger, sample, sample_valid, overrun
    );

    modport master (
        output enable, tick, step, memdir, addr_rd, data_pol, rom_data,
        input  rom_addr, trigger, sample, sample_valid, overrun
    );
endinterface

// File: rtl/dds_quadrant_reader.sv
// dds_quadrant_reader: quarter-wave ROM walker emitting signed DDS samples
// Ports: src_clk (sole clock), rst_n (async active-low reset),
//   bus (slave modport): quadrant controls and tick/step in, registered
//   rom_addr out, synchronous rom_data in, trigger/sample/sample_valid/overrun out.
module dds_quadrant_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input logic                  src_clk,
    input logic                  rst_n,
    dds_quadrant_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;

    state_t            state_q, state_d;
    logic              wait_q, wait_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              dir_q, dir_d;
    logic              trig_q, trig_d;
    logic              rd_q, rd_d;
    logic              pol_q, pol_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] res_q, res_d;
    logic [DATA_W:0]   sample_q, sample_d;
    logic [DATA_W:0]   mag;
    logic [ADDR_W:0]   sum, diff;
    logic              svc, bnd, hold;

    // One extra bit on sum/diff flags crossing either end of the table.
    assign sum  = {1'b0, addr_q} + {1'b0, bus.step};
    assign diff = {1'b0, addr_q} - {1'b0, bus.step};
    assign bnd  = dir_q ? diff[ADDR_W] : sum[ADDR_W];
    assign svc  = bus.enable && state_q == RUN && (bus.tick || pend_q);
    assign hold = state_q == WAIT || state_q == LOAD;
    assign mag  = {1'b0, bus.rom_data};

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // WAIT lasts two cycles: wait_q marks the second one.
    always_comb begin
        state_d = state_q;
        wait_d  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = LOAD;
                LOAD: state_d = RUN;
                RUN:  state_d = svc && bnd ? WAIT : RUN;
                WAIT: begin
                    state_d = wait_q ? LOAD : WAIT;
                    wait_d  = !wait_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d = addr_q;
        res_d  = res_q;
        dir_d  = dir_q;
        if (bus.enable && state_q == LOAD) begin
            addr_d = bus.memdir ? bus.addr_rd - res_q : bus.addr_rd + res_q;
            dir_d  = bus.memdir;
            res_d  = '0;
        end
        // On a boundary the address holds and the overshoot becomes the residue.
        if (svc) begin
            addr_d = bnd ? addr_q : (dir_q ? diff[ADDR_W-1:0] : sum[ADDR_W-1:0]);
            res_d  = bnd ? (dir_q ? ~diff[ADDR_W-1:0] : sum[ADDR_W-1:0]) : res_q;
        end
        if (!bus.enable)
            res_d = '0;
        pend_d   = bus.enable && hold && (pend_q || bus.tick);
        ovr_d    = bus.enable && (ovr_q || (bus.tick && pend_q));
        trig_d   = svc && bnd;
        rd_d     = svc;
        pol_d    = svc ? bus.data_pol : pol_q;
        // Polarity travels with the read so a late data_pol change is ignored.
        sample_d = rd_q ? (pol_q ? -mag : mag) : sample_q;
        valid_d  = rd_q;
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            res_q    <= '0;
            dir_q    <= 1'b0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            trig_q   <= 1'b0;
            rd_q     <= 1'b0;
            pol_q    <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            res_q    <= res_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            trig_q   <= trig_d;
            rd_q     <= rd_d;
            pol_q    <= pol_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.rom_addr     = addr_q;
    assign bus.trigger      = trig_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_dds_quadrant_reader.sv
// tb_dds_quadrant_reader: directed vector bench for dds_quadrant_reader
module tb_dds_quadrant_reader;
    localparam int AW = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dds_quadrant_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dds_quadrant_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .src_clk(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [6:0] a);
        return (a == 7'd0) ? 8'h00 : {a, 1'b1};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

    typedef struct {
        logic       dir;
        logic [6:0] start;
        logic [6:0] step;
        logic       pol;
        logic [6:0] exp_addr;
        logic       exp_trig;
        logic [8:0] exp_smp;
        logic       ld_dir;
        logic [6:0] ld_addr;
        logic [6:0] exp_ld;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [6:0] a);
        bus.enable = 1'b0;
        cyc(1);
        bus.memdir  = dir;
        bus.addr_rd = a;
        bus.enable  = 1'b1;
        cyc(2);
    endtask

    task automatic tick1(input logic pol);
        bus.tick     = 1'b1;
        bus.data_pol = pol;
        cyc(1);
        bus.tick     = 1'b0;
        bus.data_pol = ~pol;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.tick     = 1'b0;
        bus.step     = '0;
        bus.memdir   = 1'b0;
        bus.addr_rd  = '0;
        bus.data_pol = 1'b0;

        tbl[0]  = '{1'b0, 7'd0,   7'd1,   1'b0, 7'd1,   1'b0, 9'h000, 1'b0, 7'd0,   7'd0};
        tbl[1]  = '{1'b0, 7'd125, 7'd5,   1'b1, 7'd125, 1'b1, 9'h105, 1'b1, 7'd127, 7'd125};
        tbl[2]  = '{1'b1, 7'd3,   7'd5,   1'b0, 7'd3,   1'b1, 9'h007, 1'b0, 7'd0,   7'd1};
        tbl[3]  = '{1'b0, 7'd127, 7'd1,   1'b1, 7'd127, 1'b1, 9'h101, 1'b1, 7'd127, 7'd127};
        tbl[4]  = '{1'b1, 7'd0,   7'd1,   1'b1, 7'd0,   1'b1, 9'h000, 1'b0, 7'd0,   7'd0};
        tbl[5]  = '{1'b0, 7'd100, 7'd0,   1'b0, 7'd100, 1'b0, 9'h0C9, 1'b0, 7'd0,   7'd0};
        tbl[6]  = '{1'b1, 7'd127, 7'd127, 1'b0, 7'd0,   1'b0, 9'h0FF, 1'b0, 7'd0,   7'd0};
        tbl[7]  = '{1'b0, 7'd0,   7'd127, 1'b1, 7'd127, 1'b0, 9'h000, 1'b0, 7'd0,   7'd0};
        tbl[8]  = '{1'b1, 7'd10,  7'd4,   1'b1, 7'd6,   1'b0, 9'h1EB, 1'b0, 7'd0,   7'd0};
        tbl[9]  = '{1'b0, 7'd64,  7'd64,  1'b0, 7'd64,  1'b1, 9'h081, 1'b0, 7'd0,   7'd0};
        tbl[10] = '{1'b1, 7'd5,   7'd100, 1'b1, 7'd5,   1'b1, 9'h1F5, 1'b1, 7'd127, 7'd33};
        tbl[11] = '{1'b0, 7'd120, 7'd20,  1'b0, 7'd120, 1'b1, 9'h0F1, 1'b0, 7'd0,   7'd12};

        cyc(2);
        chk("rst rom_addr", bus.rom_addr, 0);
        chk("rst trigger", bus.trigger, 0);
        chk("rst sample", bus.sample, 0);
        chk("rst sample_valid", bus.sample_valid, 0);
        chk("rst overrun", bus.overrun, 0);
        rst_n = 1'b1;
        cyc(1);

        for (int i = 0; i < 12; i++) begin
            start(tbl[i].dir, tbl[i].start);
            chk($sformatf("v%0d load", i), bus.rom_addr, tbl[i].start);
            bus.step = tbl[i].step;
            tick1(tbl[i].pol);
            chk($sformatf("v%0d addr", i), bus.rom_addr, tbl[i].exp_addr);
            chk($sformatf("v%0d trigger", i), bus.trigger, tbl[i].exp_trig);
            bus.memdir  = tbl[i].ld_dir;
            bus.addr_rd = tbl[i].ld_addr;
            cyc(1);
            chk($sformatf("v%0d valid", i), bus.sample_valid, 1);
            chk($sformatf("v%0d sample", i), bus.sample, tbl[i].exp_smp);
            chk($sformatf("v%0d trigger end", i), bus.trigger, 0);
            if (tbl[i].exp_trig) begin
                cyc(2);
                chk($sformatf("v%0d reload", i), bus.rom_addr, tbl[i].exp_ld);
            end
        end

        start(1'b0, 7'd0);
        bus.step = 7'd1;
        for (int i = 0; i < 128; i++) begin
            tick1(1'b0);
            bus.data_pol = 1'b0;
            if (i < 127) begin
                chk($sformatf("sweep addr %0d", i), bus.rom_addr, i + 1);
                chk($sformatf("sweep trig %0d", i), bus.trigger, 0);
            end else begin
                chk("sweep end addr", bus.rom_addr, 127);
                chk("sweep end trig", bus.trigger, 1);
                bus.memdir  = 1'b1;
                bus.addr_rd = 7'd127;
            end
            cyc(1);
            chk($sformatf("sweep sample %0d", i), bus.sample, {1'b0, rom_f(7'(i))});
            chk($sformatf("sweep valid %0d", i), bus.sample_valid, 1);
            if (i < 127) cyc(6);
        end
        chk("sweep trig pulse", bus.trigger, 0);
        cyc(2);
        chk("sweep backward load", bus.rom_addr, 127);

        start(1'b0, 7'd125);
        bus.step = 7'd5;
        tick1(1'b0);
        chk("step5 trig", bus.trigger, 1);
        bus.memdir  = 1'b1;
        bus.addr_rd = 7'd127;
        cyc(3);
        chk("step5 reload", bus.rom_addr, 125);
        tick1(1'b0);
        chk("step5 first back", bus.rom_addr, 120);
        cyc(4);
        tick1(1'b0);
        chk("step5 second back", bus.rom_addr, 115);

        start(1'b0, 7'd126);
        bus.step     = 7'd4;
        bus.tick     = 1'b1;
        bus.data_pol = 1'b0;
        cyc(1);
        chk("burst trig", bus.trigger, 1);
        bus.memdir  = 1'b0;
        bus.addr_rd = 7'd0;
        cyc(1);
        chk("burst no overrun yet", bus.overrun, 0);
        chk("burst sample", bus.sample, 9'h0FD);
        cyc(1);
        bus.tick = 1'b0;
        chk("burst overrun", bus.overrun, 1);
        cyc(1);
        chk("burst reload", bus.rom_addr, 2);
        cyc(1);
        chk("burst pending served", bus.rom_addr, 6);
        cyc(1);
        chk("burst pending sample", bus.sample, 9'h005);
        chk("burst pending valid", bus.sample_valid, 1);
        cyc(5);
        chk("burst overrun sticky", bus.overrun, 1);
        bus.enable = 1'b0;
        cyc(1);
        chk("burst overrun cleared", bus.overrun, 0);

        start(1'b0, 7'd36);
        bus.step = 7'd1;
        tick1(1'b0);
        chk("mid addr", bus.rom_addr, 37);
        cyc(1);
        chk("mid valid", bus.sample_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rom_addr", bus.rom_addr, 0);
        chk("async sample", bus.sample, 0);
        chk("async valid", bus.sample_valid, 0);
        chk("async trigger", bus.trigger, 0);
        chk("async overrun", bus.overrun, 0);
        bus.memdir  = 1'b0;
        bus.addr_rd = 7'd50;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("post rst idle", bus.rom_addr, 0);
        cyc(1);
        chk("post rst load", bus.rom_addr, 50);

        bus.enable = 1'b0;
        cyc(1);
        tick1(1'b0);
        chk("idle tick addr", bus.rom_addr, 50);
        cyc(1);
        chk("idle tick valid", bus.sample_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
